// File: rtl/bus_slave_arb_pkg.sv
// Shared bus protocol constants and FSM encoding for the bus responder.
package bus_slave_arb_pkg;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;
  localparam logic ENABLE_   = 1'b0;
  localparam logic DISABLE_  = 1'b1;

  localparam int WORD        = 32;
  localparam int WORD_ADDR_W = 30;
  localparam int WAIT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/bus_slave_arb_rr_arbiter.sv
// Round-robin pick: first active-low request at or after ptr, wrapping modulo NUM_CH.
module rr_arbiter
  import bus_slave_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req_,
  input  logic [PTR_W-1:0]  ptr,
  output logic              valid,
  output logic [PTR_W-1:0]  sel
);

  // Scan from the farthest candidate back to ptr so the nearest request wins last.
  always_comb begin
    int              sum_s;
    logic [PTR_W-1:0] idx_s;
    logic            hit_s;
    valid = 1'b0;
    sel   = '0;
    sum_s = 0;
    idx_s = '0;
    hit_s = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sum_s = int'(ptr) + i;
      idx_s = (sum_s >= NUM_CH) ? PTR_W'(sum_s - NUM_CH) : PTR_W'(sum_s);
      hit_s = (req_[idx_s] == ENABLE_);
      sel   = hit_s ? idx_s : sel;
      valid = valid | hit_s;
    end
  end

endmodule

// File: rtl/bus_slave_arb.sv
// Multi-master bus responder: round-robin grant, bus lock, DEPTH-word RAM with wait states.
module bus_slave_arb
  import bus_slave_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             bus_req_,
  output logic [NUM_CH-1:0]             bus_grnt_,
  input  logic [NUM_CH-1:0]             bus_as_,
  input  logic [NUM_CH-1:0]             bus_rw,
  input  logic [NUM_CH*WORD_ADDR_W-1:0] bus_addr,
  input  logic [NUM_CH*WORD-1:0]        bus_wr_data,
  output logic [WORD-1:0]               bus_rd_data,
  output logic [NUM_CH-1:0]             bus_rdy_
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  state_e              state_r, state_s;
  logic [PTR_W-1:0]    owner_r, owner_s, ptr_r, ptr_s;
  logic [WAIT_W-1:0]   cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                rw_r, rw_s;
  logic [WORD-1:0]     wdata_r, wdata_s, rd_data_r, rd_data_s;
  logic [NUM_CH-1:0]   grnt_r, grnt_s, rdy_r, rdy_s;
  logic                mem_we_s, arb_valid_s;
  logic [PTR_W-1:0]    arb_sel_s;
  logic                own_req_s, own_as_s, own_rw_s;
  logic [ADDR_W-1:0]   own_addr_s;
  logic [WORD-1:0]     own_wdata_s;
  logic                unused_s;
  logic [WORD-1:0]     mem_r [DEPTH];

  rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_rr_arbiter (
    .req_  (bus_req_),
    .ptr   (ptr_r),
    .valid (arb_valid_s),
    .sel   (arb_sel_s)
  );

  // Only the owner's lanes matter; upper address bits alias onto the RAM.
  assign own_req_s   = bus_req_[owner_r];
  assign own_as_s    = bus_as_[owner_r];
  assign own_rw_s    = bus_rw[owner_r];
  assign own_addr_s  = bus_addr[int'(owner_r)*WORD_ADDR_W +: ADDR_W];
  assign own_wdata_s = bus_wr_data[int'(owner_r)*WORD +: WORD];
  assign unused_s    = ^bus_addr;

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      owner_r   <= '0;
      ptr_r     <= '0;
      cnt_r     <= '0;
      addr_r    <= '0;
      rw_r      <= BUS_READ;
      wdata_r   <= '0;
      grnt_r    <= {NUM_CH{DISABLE_}};
      rdy_r     <= {NUM_CH{DISABLE_}};
      rd_data_r <= '0;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      rw_r      <= rw_s;
      wdata_r   <= wdata_s;
      grnt_r    <= grnt_s;
      rdy_r     <= rdy_s;
      rd_data_r <= rd_data_s;
    end
  end

  // Next-state and next-output logic; rdy_ defaults high so it pulses for one cycle.
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    rw_s      = rw_r;
    wdata_s   = wdata_r;
    grnt_s    = grnt_r;
    rdy_s     = {NUM_CH{DISABLE_}};
    rd_data_s = rd_data_r;
    mem_we_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grnt_s = {NUM_CH{DISABLE_}};
        if (arb_valid_s) begin
          owner_s           = arb_sel_s;
          grnt_s[arb_sel_s] = ENABLE_;
          state_s           = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (own_as_s == ENABLE_) begin
          addr_s  = own_addr_s;
          rw_s    = own_rw_s;
          wdata_s = own_wdata_s;
          cnt_s   = WAIT_W'(WAIT_CYCLES);
          state_s = ST_ACCESS;
        end else if (own_req_s == DISABLE_) begin
          grnt_s  = {NUM_CH{DISABLE_}};
          ptr_s   = (owner_r == LAST_CH) ? '0 : owner_r + PTR_W'(1);
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_ACCESS: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - WAIT_W'(1);
        end else begin
          rdy_s[owner_r] = ENABLE_;
          state_s        = ST_GRANT;
          if (rw_r == BUS_READ) begin
            rd_data_s = mem_r[addr_r];
          end else begin
            rd_data_s = '0;
            mem_we_s  = 1'b1;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        grnt_s  = {NUM_CH{DISABLE_}};
      end
    endcase
  end

  // RAM write port; unreset so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= wdata_r;
    end
  end

  assign bus_grnt_   = grnt_r;
  assign bus_rdy_    = rdy_r;
  assign bus_rd_data = rd_data_r;

endmodule
